// File: rtl/ysyx_041461_div_unit_pkg.sv
// Shared types and constants for the iterative RV64M divide unit.
// Optional fast special-case path is enabled by defining YSYX_041461_DIV_FASTSPECIAL_EN.
package ysyx_041461_div_unit_pkg;

    localparam logic [6:0]  ITER_D = 7'd64;
    localparam logic [6:0]  ITER_W = 7'd32;
    localparam logic [63:0] MIN_D  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MIN_W  = 64'hFFFF_FFFF_8000_0000;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic is_rem;
        logic is_word;
        logic q_neg;
        logic r_neg;
    } div_op_t;

    // *W results are always sign-extended from bit 31, unsigned variants included.
    function automatic logic [63:0] wb_fmt(input logic [63:0] r, input logic word);
        return word ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

endpackage

// File: rtl/ysyx_041461_div_unit_if.sv
// Request/result handshake bundle between the execute stage (master) and the divide unit (slave).
interface ysyx_041461_div_unit_if;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        div_word;
    logic        div_rem;
    logic [63:0] div_src1;
    logic [63:0] div_src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output div_valid, div_signed, div_word, div_rem, div_src1, div_src2, flush, out_ready,
        input  div_ready, out_valid, out_data
    );

    modport slave (
        input  div_valid, div_signed, div_word, div_rem, div_src1, div_src2, flush, out_ready,
        output div_ready, out_valid, out_data
    );
endinterface

// File: rtl/ysyx_041461_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract divisor, restore on borrow.
module ysyx_041461_div_step (
    input  logic [63:0] rem_in,
    input  logic [63:0] quo_in,
    input  logic [63:0] dvs,
    output logic [63:0] rem_out,
    output logic [63:0] quo_out
);
    logic [64:0] trial;
    logic [64:0] diff;
    logic        no_borrow;

    // Shifted remainder can reach 65 bits when the divisor uses bit 63.
    assign trial     = {rem_in, quo_in[63]};
    assign diff      = trial - {1'b0, dvs};
    assign no_borrow = ~diff[64];
    assign rem_out   = no_borrow ? diff[63:0] : trial[63:0];
    assign quo_out   = {quo_in[62:0], no_borrow};
endmodule

// File: rtl/ysyx_041461_div_unit.sv
// Multi-cycle RV64M DIV/REM unit: FSM, iteration counter, sign handling and result register.
// Define YSYX_041461_DIV_FASTSPECIAL_EN to let divide-by-zero/overflow skip the iteration loop.
module ysyx_041461_div_unit
    import ysyx_041461_div_unit_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    ysyx_041461_div_unit_if.slave    bus
);
    div_state_e  state, state_nxt;
    logic [6:0]  cnt;
    logic [63:0] rem, quo, dvs, spec_val, out_q;
    div_op_t     op;
    logic        special;

    logic [63:0] a_ext, b_ext, abs_a, abs_b, spec_raw, spec_in;
    logic        sa, sb, is_zero, is_ovf, special_in, accept;
    logic [63:0] rem_step, quo_step, q_fix, r_fix, calc_res;

    assign bus.div_ready = rst_n && (state == DIV_IDLE);
    assign bus.out_valid = (state == DIV_DONE);
    assign bus.out_data  = out_q;
    assign accept        = bus.div_valid && bus.div_ready && !bus.flush;

    always_comb begin
        a_ext = bus.div_src1;
        b_ext = bus.div_src2;
        if (bus.div_word) begin
            a_ext = {{32{bus.div_signed & bus.div_src1[31]}}, bus.div_src1[31:0]};
            b_ext = {{32{bus.div_signed & bus.div_src2[31]}}, bus.div_src2[31:0]};
        end
        sa      = bus.div_signed & a_ext[63];
        sb      = bus.div_signed & b_ext[63];
        abs_a   = sa ? 64'd0 - a_ext : a_ext;
        abs_b   = sb ? 64'd0 - b_ext : b_ext;
        is_zero = (b_ext == 64'd0);
        is_ovf  = bus.div_signed && (b_ext == '1) && (a_ext == (bus.div_word ? MIN_W : MIN_D));
        special_in = is_zero | is_ovf;
        if (is_zero) spec_raw = bus.div_rem ? a_ext : '1;
        else         spec_raw = bus.div_rem ? 64'd0 : a_ext;
        spec_in = wb_fmt(spec_raw, bus.div_word);
    end

    ysyx_041461_div_step u_step (
        .rem_in  (rem),
        .quo_in  (quo),
        .dvs     (dvs),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // Final-iteration result; a latched special case overrides the datapath.
    always_comb begin
        q_fix    = op.q_neg ? 64'd0 - quo_step : quo_step;
        r_fix    = op.r_neg ? 64'd0 - rem_step : rem_step;
        calc_res = special ? spec_val : wb_fmt(op.is_rem ? r_fix : q_fix, op.is_word);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (accept) begin
`ifdef YSYX_041461_DIV_FASTSPECIAL_EN
                state_nxt = special_in ? DIV_DONE : DIV_CALC;
`else
                state_nxt = DIV_CALC;
`endif
            end
            DIV_CALC: if (cnt == 7'd1) state_nxt = DIV_DONE;
            DIV_DONE: if (bus.out_ready) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (bus.flush) state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= DIV_IDLE;
            cnt      <= 7'd0;
            rem      <= 64'd0;
            quo      <= 64'd0;
            dvs      <= 64'd0;
            op       <= '0;
            special  <= 1'b0;
            spec_val <= 64'd0;
            out_q    <= 64'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= bus.div_word ? ITER_W : ITER_D;
                rem      <= 64'd0;
                // *W dividends sit in the upper half so 32 shifts consume them.
                quo      <= bus.div_word ? {abs_a[31:0], 32'd0} : abs_a;
                dvs      <= abs_b;
                op       <= '{is_rem: bus.div_rem, is_word: bus.div_word, q_neg: sa ^ sb, r_neg: sa};
                special  <= special_in;
                spec_val <= spec_in;
`ifdef YSYX_041461_DIV_FASTSPECIAL_EN
                if (special_in) out_q <= spec_in;
`endif
            end else if (state == DIV_CALC && !bus.flush) begin
                cnt <= cnt - 7'd1;
                rem <= rem_step;
                quo <= quo_step;
                if (cnt == 7'd1) out_q <= calc_res;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_041461_div_unit.sv
// Scoreboard bench for ysyx_041461_div_unit: reference results from SV '/' and '%' plus special-case rules.
module tb_ysyx_041461_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] exp_q[$];

    ysyx_041461_div_unit_if bus();

    ysyx_041461_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_res(input logic s, w, r, input logic [63:0] a, b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)                                 r32 = r ? a32 : 32'hFFFF_FFFF;
            else if (s && a32 == 32'h8000_0000 && b32 == '1) r32 = r ? 32'd0 : a32;
            else if (s)                                       r32 = r ? $signed(a32) % $signed(b32) : $signed(a32) / $signed(b32);
            else                                              r32 = r ? a32 % b32 : a32 / b32;
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)                                           r64 = r ? a : '1;
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1)   r64 = r ? 64'd0 : a;
        else if (s)                                               r64 = r ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        else                                                      r64 = r ? a % b : a / b;
        return r64;
    endfunction

    function automatic int exp_lat(input logic s, w, input logic [63:0] a, b);
        logic spc;
        if (w) spc = (b[31:0] == 32'd0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        else   spc = (b == 64'd0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
`ifdef YSYX_041461_DIV_FASTSPECIAL_EN
        if (spc) return 1;
`endif
        return w ? 33 : 65;
    endfunction

    // Drives one request at posedge+1; returns result and latency (-1 on timeout).
    task automatic issue(input logic s, w, r, input logic [63:0] a, b, input logic ack,
                         output logic [63:0] d, output int lat);
        int n;
        exp_q.push_back(ref_res(s, w, r, a, b));
        bus.div_signed = s; bus.div_word = w; bus.div_rem = r;
        bus.div_src1 = a;   bus.div_src2 = b; bus.div_valid = 1'b1;
        n = 0;
        while (!bus.div_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.div_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!bus.out_valid) lat = -1;
        d = bus.out_data;
        if (ack && bus.out_valid) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 64'd0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
        n_cmp++; if (bus.div_ready !== 1'b0) begin n_err++; $display("FAIL rst_div_ready: got %b want 0", bus.div_ready); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.div_ready !== 1'b1) begin n_err++; $display("FAIL rel_div_ready: got %b want 1", bus.div_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_rem();
        logic [63:0] d, e;
        int lat;
        issue(1, 0, 0, -64'sd7, 64'sd2, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL div_m7_2: got %h want %h", d, e); end
        n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL div_lat: got %0d want 65", lat); end
        issue(1, 0, 1, -64'sd7, 64'sd2, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL rem_m7_2: got %h want %h", d, e); end
    endtask

    task automatic test_word();
        logic [63:0] d, e;
        int lat;
        issue(0, 1, 0, 64'hFFFF_FFFF_8000_0000, 64'd1, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL divuw_sext: got %h want %h", d, e); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divuw_lat: got %0d want 33", lat); end
        issue(0, 1, 1, 64'd7, 64'd3, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL remuw_7_3: got %h want %h", d, e); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL remuw_lat: got %0d want 33", lat); end
    endtask

    task automatic test_div_zero();
        logic [63:0] d, e;
        int lat, el;
        el = exp_lat(0, 0, 64'h1234, 64'd0);
        issue(0, 0, 0, 64'h1234, 64'd0, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL divu_zero: got %h want %h", d, e); end
        n_cmp++; if (lat !== el) begin n_err++; $display("FAIL divu_zero_lat: got %0d want %0d", lat, el); end
        issue(1, 0, 1, 64'h1234, 64'd0, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL rem_zero: got %h want %h", d, e); end
        n_cmp++; if (lat !== el) begin n_err++; $display("FAIL rem_zero_lat: got %0d want %0d", lat, el); end
    endtask

    task automatic test_overflow();
        logic [63:0] d, e;
        int lat, el;
        el = exp_lat(1, 1, 64'h8000_0000, 64'hFFFF_FFFF);
        issue(1, 1, 0, 64'h8000_0000, 64'hFFFF_FFFF, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL divw_ovf: got %h want %h", d, e); end
        n_cmp++; if (lat !== el) begin n_err++; $display("FAIL divw_ovf_lat: got %0d want %0d", lat, el); end
        issue(1, 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL remw_ovf: got %h want %h", d, e); end
        issue(1, 0, 0, 64'h8000_0000_0000_0000, '1, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL div_ovf: got %h want %h", d, e); end
    endtask

    task automatic test_hold();
        logic [63:0] d, e;
        int lat;
        issue(1, 0, 0, 64'd1000, 64'd7, 0, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL hold_data: got %h want %h", d, e); end
        for (int i = 0; i < 10; i++) begin
            bus.div_src1 = {$urandom, $urandom};
            bus.div_src2 = {$urandom, $urandom};
            bus.div_rem  = ~bus.div_rem;
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_data !== e) begin n_err++; $display("FAIL hold_stable[%0d]: got %h want %h", i, bus.out_data, e); end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.div_ready !== 1'b1) begin n_err++; $display("FAIL hold_ready_after: got %b want 1", bus.div_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid_after: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        logic [63:0] d, e;
        int lat;
        logic seen;
        bus.div_signed = 0; bus.div_word = 0; bus.div_rem = 0;
        bus.div_src1 = 64'd500; bus.div_src2 = 64'd3; bus.div_valid = 1'b1;
        @(posedge clk); #1;
        bus.div_valid = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++; if (bus.div_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle: got %b want 1", bus.div_ready); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin @(posedge clk); #1; seen |= bus.out_valid; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_result: got %b want 0", seen); end
        // Request coincident with flush must not be taken.
        bus.div_src1 = 64'd9; bus.div_src2 = 64'd2; bus.div_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.div_valid = 1'b0; bus.flush = 1'b0;
        n_cmp++; if (bus.div_ready !== 1'b1) begin n_err++; $display("FAIL flush_block_accept: got %b want 1", bus.div_ready); end
        issue(0, 0, 0, 64'd100, 64'd7, 1, d, lat);
        e = exp_q.pop_front();
        n_cmp++; if (d !== e) begin n_err++; $display("FAIL flush_then_div: got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.div_signed = 1; bus.div_word = 0; bus.div_rem = 0;
        bus.div_src1 = 64'd12345; bus.div_src2 = 64'd11; bus.div_valid = 1'b1;
        @(posedge clk); #1;
        bus.div_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 64'd0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", bus.out_data); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.div_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", bus.div_ready); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin @(posedge clk); #1; seen |= bus.out_valid; end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_result: got %b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d, e, a, b;
        logic s, w, r;
        int lat, el;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom); w = 1'($urandom); r = 1'($urandom);
            a = {$urandom, $urandom};
            b = (i % 3 == 0) ? 64'($urandom_range(1, 100)) : {$urandom, $urandom};
            if (i == 5) b = 64'd0;
            if (i == 6) b = 64'($urandom_range(1, 9));
            el = exp_lat(s, w, a, b);
            issue(s, w, r, a, b, 1, d, lat);
            e = exp_q.pop_front();
            n_cmp++; if (d !== e) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, d, e); end
            n_cmp++; if (lat !== el) begin n_err++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, lat, el); end
            n_cmp++; if (bus.div_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.div_ready); end
        end
    endtask

    initial begin
        bus.div_valid = 1'b0; bus.div_signed = 1'b0; bus.div_word = 1'b0; bus.div_rem = 1'b0;
        bus.div_src1 = 64'd0; bus.div_src2 = 64'd0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_div_rem();
        test_word();
        test_div_zero();
        test_overflow();
        test_hold();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
